// File: rtl/instruction_fetch_controller_pkg.sv
// instruction_fetch_controller_pkg: shared fetch FSM encoding and default reset vector
package instruction_fetch_controller_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;
endpackage

// File: rtl/instruction_fetch_controller_fetch_fifo.sv
// fetch_fifo: in-order fetch buffer with flush, head reads zero while empty
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full
);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic do_pop, do_push;
  assign do_pop = pop && count != '0 && !flush;
  assign do_push = push && (count != FULL_COUNT || do_pop) && !flush;
  assign full = count == FULL_COUNT;
  assign dout = count != '0 ? mem[head] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop) head <= head + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end
endmodule

// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: pc sequencing, redirect/halt FSM and fetch buffer for decode
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);
  state_t state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic push, pop, flush, full;
  logic [$clog2(FIFO_DEPTH):0] count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WARMUP;
      pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
    end
  end
  always_comb begin
    pop = out_valid && out_ready;
    flush = redirect_valid && state != WARMUP;
    push = state == FETCH && !redirect_valid && !halt && (!full || pop);
    pc_nxt = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc + 32'd4 : pc;
    state_nxt = (state == WARMUP || redirect_valid) ? FETCH :
                (state == FETCH && halt) ? HALTED : state;
  end
  assign imem_addr = pc;
  assign out_valid = count != '0;
  assign halted = state == HALTED;
  fetch_fifo #(
    .WIDTH(64),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din({pc, imem_data}),
    .dout({out_pc, out_instr}),
    .count(count),
    .full(full)
  );
endmodule
